// File: rtl/ex_div.sv
// ex_div: 32-bit restoring divider for the EX stage, signed (DIV) and unsigned (DIVU).
// The result is {remainder, quotient}, registered and held while start_i stays high.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, produce an all-zero result next edge
// ON     | one shift-subtract step per edge, 32 steps
// END    | result valid, held until start_i drops
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } div_state_t;

    div_state_t state, state_nxt;

    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        last_step;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FREE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) state_nxt = (opdata2_i == 32'd0) ? BYZERO : ON;
            end
            BYZERO: begin
                state_nxt = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i)        state_nxt = FREE;
                else if (last_step) state_nxt = END;
            end
            END: begin
                if (!start_i) state_nxt = FREE;
            end
            default: state_nxt = FREE;
        endcase
    end

    // Operand magnitudes, one restoring step, and final sign correction
    always_comb begin
        accept    = start_i && !annul_i;
        last_step = (cnt == 6'd31);
        dvd_neg   = signed_div_i && opdata1_i[31];
        dvs_neg   = signed_div_i && opdata2_i[31];
        dvd_abs   = dvd_neg ? (32'd0 - opdata1_i) : opdata1_i;
        dvs_abs   = dvs_neg ? (32'd0 - opdata2_i) : opdata2_i;
        // rem < dvs always, so the shifted remainder fits in 33 bits and
        // bit 32 of the difference is a clean borrow flag
        rem_sh    = {rem, quo[31]};
        diff      = rem_sh - {1'b0, dvs};
        rem_nxt   = diff[32] ? rem_sh[31:0] : diff[31:0];
        quo_nxt   = {quo[30:0], ~diff[32]};
        rem_fix   = neg_r ? (32'd0 - rem_nxt) : rem_nxt;
        quo_fix   = neg_q ? (32'd0 - quo_nxt) : quo_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvs      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (accept) begin
                        cnt   <= 6'd0;
                        rem   <= 32'd0;
                        quo   <= dvd_abs;
                        dvs   <= dvs_abs;
                        neg_q <= dvd_neg ^ dvs_neg;
                        neg_r <= dvd_neg;
                    end
                end
                BYZERO: begin
                    ready_o  <= !annul_i;
                    result_o <= 64'd0;
                end
                ON: begin
                    if (annul_i) begin
                        cnt      <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 6'd1;
                        if (last_step) begin
                            ready_o  <= 1'b1;
                            result_o <= {rem_fix, quo_fix};
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors for ex_div with hand-computed results and latencies.
// Latency counts the accepting edge as edge 1.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for ready_o, counting edges from the accepting edge.
    task automatic wait_ready(output int n, input bit scramble, input logic sgn);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready_o) break;
            if (scramble && n == 3) begin
                opdata1_i    = 32'h1234_5678;
                opdata2_i    = 32'h0000_0003;
                signed_div_i = ~sgn;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_lat, input bit scramble);
        int n;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        wait_ready(n, scramble, sgn);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, result_o, exp);
        @(posedge clk); #1;
        chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_res"}, result_o, exp);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_free_rdy"}, 64'(ready_o), 64'd0);
        chk({tag, "_free_res"}, result_o, 64'd0);
    endtask

    initial begin
        int  n;
        bit  rose;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(ready_o), 64'd0);
        chk("rst_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("u100_7",   1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                 33, 1'b0);
        run_div("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 1'b0);
        run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},         33, 1'b0);
        run_div("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0, 32'hFFFF_FFFF},          33, 1'b0);
        run_div("u_80_ff",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0},         33, 1'b0);
        run_div("div0",     1'b0, 32'd5,          32'd0,        64'd0,                           2,  1'b0);
        run_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000},         33, 1'b1);

        // annul held in FREE must block acceptance
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) rose = 1'b1;
        end
        chk("free_annul_rdy", 64'(rose), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // annul on the 10th ON edge (edge 11 counting acceptance as 1)
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0;
        start_i = 1'b1;
        rose = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            if (ready_o) rose = 1'b1;
            if (i == 10) annul_i = 1'b1;
        end
        chk("annul_rdy", 64'(ready_o), 64'd0);
        chk("annul_res", result_o, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) rose = 1'b1;
        end
        chk("annul_never_rdy", 64'(rose), 64'd0);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

        // rst at step 20 of ON, start held, restart on first edge after rst drops
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        start_i = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(posedge clk); #1;
            if (i == 20) rst = 1'b1;
        end
        chk("midrst_rdy", 64'(ready_o), 64'd0);
        chk("midrst_res", result_o, 64'd0);
        rst = 1'b0;
        wait_ready(n, 1'b0, 1'b0);
        chk("restart_lat", 64'(n), 64'd33);
        chk("restart_res", result_o, {32'd1, 32'd333});
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("restart_free_rdy", 64'(ready_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL take no parameters; operand width is fixed at 32 bits and result width at 64 bits.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 opdata1_i  input  32  dividend.
REQ-006 opdata2_i  input  32  divisor.
REQ-007 start_i  input  1  request from the EX stage; held high until the result has been taken.
REQ-008 annul_i  input  1  cancels the operation in progress (flush or exception).
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}, consumed by EX as ex_hi/ex_lo.
REQ-010 ready_o  output  1  result_o is valid.

Function
REQ-011 The block SHALL implement four states: FREE, BYZERO, ON, END, with a 6-bit iteration counter.
REQ-012 In FREE with start_i=1 and annul_i=0, the block SHALL latch opdata1_i, opdata2_i and signed_div_i on that edge and go to BYZERO if opdata2_i==0, otherwise to ON with the counter at 0.
REQ-013 In FREE, start_i SHALL be ignored while annul_i=1.
REQ-014 The signed mode SHALL divide absolute values; the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-015 In ON, each edge SHALL perform one restoring shift-subtract step yielding one quotient bit (MSB first), for 32 steps.
REQ-016 After the 32nd step, the block SHALL enter END, driving ready_o=1 and result_o={remainder, quotient} as registered values on that edge.
REQ-017 Latency SHALL be 33 rising edges from the accepting edge to ready_o=1 for a non-zero divisor.
REQ-018 In ON, operand input changes SHALL be ignored.
REQ-019 In ON, annul_i=1 SHALL return the block to FREE on the next edge, with ready_o=0 and result_o=0.
REQ-020 BYZERO SHALL go to END on the next edge with result_o=64'h0 and ready_o=1; annul_i=1 in BYZERO SHALL go to FREE instead.
REQ-021 END SHALL hold result_o and ready_o stable while start_i=1 and SHALL ignore annul_i.
REQ-022 In END with start_i=0, the block SHALL go to FREE on the next edge with ready_o=0 and result_o=0.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-024 ready_o SHALL be 0 in every state other than END.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter FREE with counter=0, ready_o=0, result_o=64'h0, and latched operands cleared.
REQ-026 rst SHALL take priority over start_i and annul_i in every state, including mid-ON.
REQ-027 After rst deasserts, a start_i=1 SHALL be accepted on the first edge.

Verification
REQ-028 Unsigned 100/7, start held -> ready_o=1 exactly 33 edges after acceptance; result_o={32'd2, 32'd14}.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; unsigned 0xFFFFFFFF/1 -> {32'h0, 32'hFFFFFFFF}.
REQ-030 Divisor 0 (5/0) -> ready_o=1 two edges after acceptance, result_o=64'h0; deassert start_i -> FREE, ready_o=0 next edge.
REQ-031 annul_i pulsed on the 10th ON edge -> FREE next edge; ready_o never rises; a subsequent 9/3 returns {32'd0, 32'd3} after 33 edges.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> {32'h0, 32'h80000000}; operands changed mid-ON do not alter the result.
REQ-033 rst asserted at step 20 of ON -> next edge FREE, ready_o=0, result_o=0; start_i held high -> restart accepted on the first edge after rst drops.
